decoder_stream: RTL and testbench



---
 rtl/decoder_pkg.sv | 36 +++
 rtl/decoder_stream_if.sv | 37 +++
 rtl/decoder_core.sv | 29 ++
 rtl/decoder_stream.sv | 110 +++++++++++
 tb/tb_decoder_stream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : decoder_pkg                                           |
// | Purpose  : Shared constants, types and helper function for the   |
// |            streaming binary-to-one-hot decoder.                  |
// | Contents : DEF_IN_W / DEF_OUT_W / DEF_CNT_W default widths,      |
// |            onehot_t word type, occ_e buffer occupancy states,    |
// |            onehot_of() reference decode for default widths.      |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package decoder_pkg;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef logic [DEF_OUT_W-1:0] onehot_t;

  // Output buffer occupancy; the encoding doubles as the word count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Decode a default-width code; a cleared enable yields an all-zero word.
  function automatic onehot_t onehot_of(input logic [DEF_IN_W-1:0] code,
                                        input logic                en);
    onehot_t word;
    word = '0;
    if (en) word[code] = 1'b1;
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_stream_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : decoder_stream_if                                     |
// | Purpose  : Input and output valid/ready streams of the decoder.  |
// | Ports    : in_valid/in_ready/in_code/in_en   code stream         |
// |            out_valid/out_ready/out_onehot    one-hot stream      |
// |            master modport : producer + consumer side             |
// |            slave modport  : decoder side                         |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface decoder_stream_if
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;

  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_onehot
  );

  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_onehot
  );

endinterface
`default_nettype wire

// File: rtl/decoder_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : decoder_core                                          |
// | Purpose  : Purely combinational binary code -> one-hot decode.   |
// | Ports    : code   [IN_W]   binary code                           |
// |            en     [1]      decode enable (0 -> all-zero word)    |
// |            onehot [OUT_W]  decoded word                          |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  code,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  // OUT_W == 2**IN_W is enforced by the instantiating block, so every
  // code value indexes a real bit.
  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/decoder_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : decoder_stream                                        |
// | Purpose  : Streaming 3-to-8 decoder with a 2-entry output buffer |
// |            and a wrapping count of delivered words.              |
// | Ports    : clk       clock, rising edge                          |
// |            rst_n     asynchronous active-low reset               |
// |            strm      decoder_stream_if.slave (code in, word out) |
// |            xfer_cnt  [CNT_W] output handshakes, wrapping         |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_stream_if.slave     strm,
  output logic [CNT_W-1:0]    xfer_cnt
);

  generate
    if (OUT_W != (1 << IN_W)) begin : g_bad_width
      $error("decoder_stream: OUT_W must equal 2**IN_W");
    end
  endgenerate

  occ_e             occ_q;
  occ_e             occ_d;
  logic [OUT_W-1:0] word;
  logic [OUT_W-1:0] slot0;
  logic [OUT_W-1:0] slot1;
  logic             push;
  logic             pop;

  // Decode happens at the capture point so the buffer stores final words.
  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .code   (strm.in_code),
    .en     (strm.in_en),
    .onehot (word)
  );

  // in_ready depends on registered occupancy only, so there is no
  // combinational path from out_ready back to the producer.
  assign strm.in_ready   = (occ_q != OCC_FULL);
  assign strm.out_valid  = (occ_q != OCC_EMPTY);
  assign strm.out_onehot = strm.out_valid ? slot0 : '0;

  assign push = strm.in_valid  & strm.in_ready;
  assign pop  = strm.out_valid & strm.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: if (push) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_d = OCC_FULL;
        else if (!push && pop) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // Slot data; vacated slots are cleared so no stale word can resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (push) slot0 <= word;
        OCC_ONE: begin
          // Push+pop replaces the head in place: full rate, no bubble.
          if (push && pop) slot0 <= word;
          else if (push)   slot1 <= word;
          else if (pop)    slot0 <= '0;
        end
        OCC_FULL: begin
          if (pop) begin
            slot0 <= slot1;
            slot1 <= '0;
          end
        end
        default: begin
          slot0 <= '0;
          slot1 <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_decoder_stream                                     |
// | Purpose  : Self-checking bench for decoder_stream: vector table, |
// |            directed corner sequences and randomized traffic      |
// |            against a queue-based reference model.                |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_decoder_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] xfer_cnt;

  decoder_stream_if #(.IN_W(3), .OUT_W(8)) ifc ();

  decoder_stream #(
    .IN_W  (3),
    .OUT_W (8),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strm     (ifc),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total_checks;
  int unsigned passed_checks;

  // Reference model: the buffer is just a FIFO of expected words.
  logic [7:0]  mq[$];
  logic [15:0] exp_cnt;

  typedef struct {
    logic [2:0] code;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      passed_checks++;
  endtask

  // Called mid-cycle (after the falling edge): compare DUT to model,
  // predict the handshakes of the next rising edge, then advance.
  task automatic cycle();
    logic       in_hs;
    logic       out_hs;
    logic [7:0] w;
    check("in_ready",   {31'd0, ifc.in_ready},  {31'd0, mq.size() != 2});
    check("out_valid",  {31'd0, ifc.out_valid}, {31'd0, mq.size() != 0});
    check("out_onehot", {24'd0, ifc.out_onehot}, {24'd0, (mq.size() != 0) ? mq[0] : 8'h00});
    check("xfer_cnt",   {16'd0, xfer_cnt}, {16'd0, exp_cnt});
    in_hs  = ifc.in_valid  && (mq.size() != 2);
    out_hs = ifc.out_ready && (mq.size() != 0);
    w      = ifc.in_en ? 8'(2 ** ifc.in_code) : 8'h00;
    @(posedge clk);
    if (out_hs) begin
      void'(mq.pop_front());
      exp_cnt = exp_cnt + 16'd1;
    end
    if (in_hs) mq.push_back(w);
    @(negedge clk);
  endtask

  initial begin
    int n;
    total_checks  = 0;
    passed_checks = 0;
    exp_cnt       = 16'd0;

    vecs[0] = '{3'd0, 1'b1, 8'h01};
    vecs[1] = '{3'd1, 1'b1, 8'h02};
    vecs[2] = '{3'd2, 1'b1, 8'h04};
    vecs[3] = '{3'd3, 1'b1, 8'h08};
    vecs[4] = '{3'd4, 1'b1, 8'h10};
    vecs[5] = '{3'd5, 1'b1, 8'h20};
    vecs[6] = '{3'd6, 1'b1, 8'h40};
    vecs[7] = '{3'd7, 1'b1, 8'h80};

    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_code   = 3'd0;
    ifc.in_en     = 1'b0;
    ifc.out_ready = 1'b0;

    // Reset state.
    #1;
    check("rst_out_valid",  {31'd0, ifc.out_valid}, 32'd0);
    check("rst_out_onehot", {24'd0, ifc.out_onehot}, 32'd0);
    check("rst_xfer_cnt",   {16'd0, xfer_cnt}, 32'd0);
    check("rst_in_ready",   {31'd0, ifc.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Codes 0..7 streamed back to back, each visible one cycle later.
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_code  = vecs[i].code;
      ifc.in_en    = vecs[i].en;
      cycle();
      check("vec_onehot", {24'd0, ifc.out_onehot}, {24'd0, vecs[i].exp});
      check("vec_valid",  {31'd0, ifc.out_valid}, 32'd1);
    end
    ifc.in_valid = 1'b0;
    cycle();
    check("cnt_after_8", {16'd0, xfer_cnt}, 32'd8);

    // Disabled decode still delivers (an all-zero word) and counts.
    ifc.in_valid = 1'b1;
    ifc.in_code  = 3'd5;
    ifc.in_en    = 1'b0;
    cycle();
    check("en0_onehot", {24'd0, ifc.out_onehot}, 32'h00);
    check("en0_valid",  {31'd0, ifc.out_valid}, 32'd1);
    ifc.in_valid = 1'b0;
    cycle();
    check("en0_cnt", {16'd0, xfer_cnt}, 32'd9);

    // Stall: fill both slots, hold, then drain in order.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_en     = 1'b1;
    ifc.in_code   = 3'd3;
    cycle();
    check("stall_ready1", {31'd0, ifc.in_ready}, 32'd1);
    ifc.in_code = 3'd6;
    cycle();
    check("stall_ready0", {31'd0, ifc.in_ready}, 32'd0);
    check("stall_head",   {24'd0, ifc.out_onehot}, 32'h08);
    for (int i = 0; i < 3; i++) begin
      ifc.in_code = 3'($urandom_range(0, 7));
      ifc.in_en   = 1'($urandom_range(0, 1));
      cycle();
      check("stall_hold", {24'd0, ifc.out_onehot}, 32'h08);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    cycle();
    check("drain_second",   {24'd0, ifc.out_onehot}, 32'h40);
    check("drain_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    cycle();
    check("drain_empty", {31'd0, ifc.out_valid}, 32'd0);
    check("drain_cnt",   {16'd0, xfer_cnt}, 32'd11);

    // Sustained push+pop at occupancy 1.
    ifc.in_valid  = 1'b1;
    ifc.in_en     = 1'b1;
    ifc.in_code   = 3'($urandom_range(0, 7));
    cycle();
    for (int i = 0; i < 100; i++) begin
      ifc.in_code = 3'($urandom_range(0, 7));
      cycle();
      check("flow_in_ready",  {31'd0, ifc.in_ready}, 32'd1);
      check("flow_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    end
    ifc.in_valid = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = 1'($urandom_range(0, 1));
      ifc.in_code   = 3'($urandom_range(0, 7));
      ifc.in_en     = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    cycle();
    cycle();

    // Counter wrap: run transfers until the count reaches 0xFFFF.
    ifc.in_valid = 1'b1;
    n = 0;
    while (exp_cnt != 16'hFFFF && n < 70000) begin
      ifc.in_code = 3'($urandom_range(0, 7));
      ifc.in_en   = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    check("cnt_ffff", {16'd0, xfer_cnt}, 32'h0000_FFFF);
    ifc.in_valid = 1'b0;
    cycle();
    check("cnt_wrap", {16'd0, xfer_cnt}, 32'h0000_0000);

    // Asynchronous reset with two words buffered.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_en     = 1'b1;
    ifc.in_code   = 3'd1;
    cycle();
    ifc.in_code = 3'd2;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid",  {31'd0, ifc.out_valid}, 32'd0);
    check("arst_out_onehot", {24'd0, ifc.out_onehot}, 32'd0);
    check("arst_xfer_cnt",   {16'd0, xfer_cnt}, 32'd0);
    mq.delete();
    exp_cnt       = 16'd0;
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    rst_n        = 1'b1;
    cycle();
    check("post_rst_in_ready",  {31'd0, ifc.in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    cycle();
    check("post_rst_no_stale", {31'd0, ifc.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
